sram_arbiter: RTL and testbench

Time-multiplexes the board's external 32-bit SRAM (two 16-bit chips, shared 18-bit address, active-low strobes) between a write requester (pixel buffer) and a read requester (dump sequencer). Replaces the static source-select mux, so capture and RS232C dump can overlap. Sits in the f50 clock domain between those two clients and the SRAM pad tristates in top. Write priority is the default, with a bounded-starvation guard for reads.

---
 rtl/sram_arb_pkg.sv | 31 +++
 rtl/sram_arb_pick.sv | 48 ++++
 rtl/sram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arb_pkg
//  Description : Shared widths, default timing parameters and the state
//                encoding for the external SRAM arbiter.
//  Contents    : c_ADDR_W / c_DATA_W   - SRAM word address and data widths
//                c_WAIT_CYC_DEF        - default WE / OE-to-sample length
//                c_STARVE_MAX_DEF      - default write grants before a read
//                c_CNT_W               - width of the small cycle counters
//                state_e               - access sequencer states
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

    localparam int c_ADDR_W         = 18;
    localparam int c_DATA_W         = 32;
    localparam int c_WAIT_CYC_DEF   = 2;
    localparam int c_STARVE_MAX_DEF = 4;
    localparam int c_CNT_W          = 4;   // holds 0..15, the legal range of both knobs

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_SETUP = 3'd1,
        S_WR_PULSE = 3'd2,
        S_WR_HOLD  = 3'd3,
        S_RD_WAIT  = 3'd4,
        S_RD_DONE  = 3'd5
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sram_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arb_pick
//  Description : Grant decision for the SRAM arbiter. Writes win by default;
//                after STARVE_MAX consecutive write grants with a read
//                waiting, the read is granted instead.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                wr_req, rd_req      - client requests
//                idle                - sequencer is in IDLE (grants only then)
//                grant_wr, grant_rd  - combinational one-hot grant
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_arb_pick
    import sram_arb_pkg::*;
#(
    parameter int STARVE_MAX = c_STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic wr_req,
    input  logic rd_req,
    input  logic idle,
    output logic grant_wr,
    output logic grant_rd
);

    localparam logic [c_CNT_W-1:0] c_STARVE_LIM = STARVE_MAX[c_CNT_W-1:0];

    logic [c_CNT_W-1:0] r_starveCnt;
    logic               w_starved;

    // A read has waited long enough only while it is actually pending.
    assign w_starved = rd_req && (r_starveCnt == c_STARVE_LIM);
    assign grant_wr  = idle && wr_req && !w_starved;
    assign grant_rd  = idle && rd_req && !grant_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starveCnt <= '0;
        end else if (!rd_req || grant_rd) begin
            r_starveCnt <= '0;
        end else if (grant_wr && (r_starveCnt != c_STARVE_LIM)) begin
            r_starveCnt <= r_starveCnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter
//  Description : Time-multiplexes the external 32-bit SRAM (two 16-bit chips,
//                shared address, active-low strobes) between a write client
//                and a read client. Every access returns to IDLE for at least
//                one cycle, giving bus turnaround between FPGA and SRAM drive.
//  Ports       : clk, reset                  - f50 clock, sync active-high reset
//                wr_req/wr_addr/wr_data      - write client, held until wr_ack
//                wr_ack                      - one-cycle write completion pulse
//                rd_req/rd_addr              - read client, held until rd_valid
//                rd_data/rd_valid            - read result and its one-cycle pulse
//                xonOE/xonWE/xopAddr         - SRAM strobes (active-low), address
//                xonCE*/xonUB*/xonLB*        - chip enables and byte lanes
//                sram_wd/sram_dq_oe/sram_rd  - pad write data, drive enable, read data
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WAIT_CYC   = c_WAIT_CYC_DEF,
    parameter int STARVE_MAX = c_STARVE_MAX_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_req,
    input  logic [c_ADDR_W-1:0] wr_addr,
    input  logic [c_DATA_W-1:0] wr_data,
    output logic                wr_ack,
    input  logic                rd_req,
    input  logic [c_ADDR_W-1:0] rd_addr,
    output logic [c_DATA_W-1:0] rd_data,
    output logic                rd_valid,
    output logic                xonOE,
    output logic                xonWE,
    output logic [c_ADDR_W-1:0] xopAddr,
    output logic                xonCE1,
    output logic                xonUB1,
    output logic                xonLB1,
    output logic                xonCE2,
    output logic                xonUB2,
    output logic                xonLB2,
    output logic [c_DATA_W-1:0] sram_wd,
    output logic                sram_dq_oe,
    input  logic [c_DATA_W-1:0] sram_rd
);

    // WR_PULSE lasts WAIT_CYC cycles, RD_WAIT lasts WAIT_CYC+1; both count down to 0.
    localparam logic [c_CNT_W-1:0] c_PULSE_LOAD  = WAIT_CYC[c_CNT_W-1:0] - 1'b1;
    localparam logic [c_CNT_W-1:0] c_RDWAIT_LOAD = WAIT_CYC[c_CNT_W-1:0];

    state_e             r_state;
    state_e             w_nextState;
    logic [c_CNT_W-1:0] r_waitCnt;
    logic [c_CNT_W-1:0] w_nextWaitCnt;
    logic               w_grantWr;
    logic               w_grantRd;
    logic               w_capture;
    logic               w_writing;
    logic               w_selected;

    sram_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk      (clk),
        .reset    (reset),
        .wr_req   (wr_req),
        .rd_req   (rd_req),
        .idle     (r_state == S_IDLE),
        .grant_wr (w_grantWr),
        .grant_rd (w_grantRd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_waitCnt <= '0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextWaitCnt;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_nextWaitCnt = r_waitCnt;
        w_capture     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grantWr) begin
                    w_nextState = S_WR_SETUP;
                end else if (w_grantRd) begin
                    w_nextState   = S_RD_WAIT;
                    w_nextWaitCnt = c_RDWAIT_LOAD;
                end
            end
            S_WR_SETUP: begin
                w_nextState   = S_WR_PULSE;
                w_nextWaitCnt = c_PULSE_LOAD;
            end
            S_WR_PULSE: begin
                if (r_waitCnt == '0) begin
                    w_nextState = S_WR_HOLD;
                end else begin
                    w_nextWaitCnt = r_waitCnt - 1'b1;
                end
            end
            S_WR_HOLD: w_nextState = S_IDLE;
            S_RD_WAIT: begin
                if (r_waitCnt == '0) begin
                    w_nextState = S_RD_DONE;
                    w_capture   = 1'b1;   // last OE-low cycle: sample the pads
                end else begin
                    w_nextWaitCnt = r_waitCnt - 1'b1;
                end
            end
            S_RD_DONE: w_nextState = S_IDLE;
            default:   w_nextState = S_IDLE;
        endcase
    end

    // Pad controls are decoded from the next state and registered, so they
    // change on the same edge as the state they belong to.
    assign w_writing  = (w_nextState == S_WR_SETUP) || (w_nextState == S_WR_PULSE) ||
                        (w_nextState == S_WR_HOLD);
    assign w_selected = w_writing || (w_nextState == S_RD_WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            xonOE      <= 1'b1;
            xonWE      <= 1'b1;
            xonCE1     <= 1'b1;
            xonUB1     <= 1'b1;
            xonLB1     <= 1'b1;
            xonCE2     <= 1'b1;
            xonUB2     <= 1'b1;
            xonLB2     <= 1'b1;
            xopAddr    <= '0;
            sram_wd    <= '0;
            rd_data    <= '0;
            sram_dq_oe <= 1'b0;
            wr_ack     <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            xonOE      <= (w_nextState != S_RD_WAIT);
            xonWE      <= (w_nextState != S_WR_PULSE);
            xonCE1     <= !w_selected;
            xonUB1     <= !w_selected;
            xonLB1     <= !w_selected;
            xonCE2     <= !w_selected;
            xonUB2     <= !w_selected;
            xonLB2     <= !w_selected;
            sram_dq_oe <= w_writing;
            wr_ack     <= (w_nextState == S_WR_HOLD);
            rd_valid   <= (w_nextState == S_RD_DONE);
            // Address and data are latched at grant and held for the access.
            if (w_grantWr) begin
                xopAddr <= wr_addr;
                sram_wd <= wr_data;
            end else if (w_grantRd) begin
                xopAddr <= rd_addr;
            end
            if (w_capture) begin
                rd_data <= sram_rd;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_arbiter
//  Description : Directed self-checking bench for sram_arbiter with a simple
//                behavioural SRAM behind the pads.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_req;
    logic [17:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic        rd_req;
    logic [17:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        xonOE, xonWE;
    logic [17:0] xopAddr;
    logic        xonCE1, xonUB1, xonLB1, xonCE2, xonUB2, xonLB2;
    logic [31:0] sram_wd;
    logic        sram_dq_oe;
    logic [31:0] sram_rd;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    sram_arbiter #(.WAIT_CYC(2), .STARVE_MAX(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .xonOE      (xonOE),
        .xonWE      (xonWE),
        .xopAddr    (xopAddr),
        .xonCE1     (xonCE1),
        .xonUB1     (xonUB1),
        .xonLB1     (xonLB1),
        .xonCE2     (xonCE2),
        .xonUB2     (xonUB2),
        .xonLB2     (xonLB2),
        .sram_wd    (sram_wd),
        .sram_dq_oe (sram_dq_oe),
        .sram_rd    (sram_rd)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: writes while WE and CE are low, reads combinationally.
    logic [31:0] mem [0:262143];
    logic        pokeEn = 1'b0;
    logic [17:0] pokeAddr = '0;
    logic [31:0] pokeData = '0;

    always @(posedge clk) begin
        if (pokeEn) mem[pokeAddr] <= pokeData;
        else if (!xonWE && !xonCE1 && !xonCE2) mem[xopAddr] <= sram_wd;
    end
    assign sram_rd = (!xonOE && !xonCE1) ? mem[xopAddr] : 32'h0;

    always @(negedge clk) begin
        if (started) begin
            assert (!(sram_dq_oe && !xonOE)) else $error("bus contention: dq_oe with OE low");
            assert (!(!xonWE && !xonOE)) else $error("WE and OE low together");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [17:0] a, input logic [31:0] d);
        pokeAddr = a;
        pokeData = d;
        pokeEn   = 1'b1;
        tick();
        pokeEn   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        repeat (3) tick();
        started = 1'b1;
        checks++;
        if ({xonOE, xonWE, xonCE1, xonUB1, xonLB1, xonCE2, xonUB2, xonLB2} !== 8'hFF) begin
            failures++;
            $display("FAIL reset_strobes got %b want 11111111",
                     {xonOE, xonWE, xonCE1, xonUB1, xonLB1, xonCE2, xonUB2, xonLB2});
        end
        checks++;
        if ({xopAddr, sram_wd, rd_data} !== 82'h0) begin
            failures++;
            $display("FAIL reset_data addr=%h wd=%h rd=%h want all 0", xopAddr, sram_wd, rd_data);
        end
        checks++;
        if ({sram_dq_oe, wr_ack, rd_valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got %b want 000", {sram_dq_oe, wr_ack, rd_valid});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_only();
        int ackAt = -1, acks = 0, weLow = 0, dqOe = 0;
        bit wdOk = 1'b1, addrOk = 1'b1;
        wr_addr = 18'h00010; wr_data = 32'hDEADBEEF; wr_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (!xonWE) weLow++;
            if (sram_dq_oe) begin
                dqOe++;
                if (sram_wd !== 32'hDEADBEEF) wdOk = 1'b0;
                if (xopAddr !== 18'h00010) addrOk = 1'b0;
            end
            if (wr_ack) begin
                acks++;
                if (ackAt < 0) ackAt = k;
                wr_req = 1'b0;
            end
        end
        checks++; if (ackAt != 4) begin failures++; $display("FAIL wr_ack_cycle got %0d want 4", ackAt); end
        checks++; if (acks != 1) begin failures++; $display("FAIL wr_ack_count got %0d want 1", acks); end
        checks++; if (weLow != 2) begin failures++; $display("FAIL wr_we_low got %0d want 2", weLow); end
        checks++; if (dqOe != 4) begin failures++; $display("FAIL wr_dq_oe_cycles got %0d want 4", dqOe); end
        checks++; if (!wdOk) begin failures++; $display("FAIL wr_data_driven got %h want deadbeef", sram_wd); end
        checks++; if (!addrOk) begin failures++; $display("FAIL wr_addr_driven got %h want 00010", xopAddr); end
        checks++;
        if (mem[18'h00010] !== 32'hDEADBEEF) begin
            failures++; $display("FAIL wr_mem got %h want deadbeef", mem[18'h00010]);
        end
        tick();
    endtask

    task automatic read_check(input string tag, input logic [17:0] a, input logic [31:0] expData);
        int vAt = -1, valids = 0, oeLow = 0;
        logic [31:0] got = '0;
        rd_addr = a; rd_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (!xonOE) oeLow++;
            if (rd_valid) begin
                valids++;
                if (vAt < 0) begin vAt = k; got = rd_data; end
                rd_req = 1'b0;
            end
        end
        checks++; if (vAt != 4) begin failures++; $display("FAIL %s_valid_cycle got %0d want 4", tag, vAt); end
        checks++; if (oeLow != 3) begin failures++; $display("FAIL %s_oe_low got %0d want 3", tag, oeLow); end
        checks++; if (got !== expData) begin failures++; $display("FAIL %s_data got %h want %h", tag, got, expData); end
        checks++; if (rd_data !== expData) begin failures++; $display("FAIL %s_data_held got %h want %h", tag, rd_data, expData); end
        checks++; if (valids != 1) begin failures++; $display("FAIL %s_valid_count got %0d want 1", tag, valids); end
    endtask

    task automatic test_read_only();
        poke(18'h3FFFF, 32'h12345678);
        read_check("rd", 18'h3FFFF, 32'h12345678);
        tick();
    endtask

    task automatic test_starvation();
        logic [9:0] seq = '0;
        int n = 0, run = 0, maxRun = 0;
        bit rdOk = 1'b1;
        wr_addr = 18'h00200; wr_data = 32'h00000055;
        rd_addr = 18'h00010;
        wr_req = 1'b1; rd_req = 1'b1;
        for (int c = 0; c < 100 && n < 10; c++) begin
            tick();
            if (wr_ack) begin
                seq = {seq[8:0], 1'b1}; n++; run++;
                if (run > maxRun) maxRun = run;
            end
            if (rd_valid) begin
                seq = {seq[8:0], 1'b0}; n++; run = 0;
                if (rd_data !== 32'hDEADBEEF) rdOk = 1'b0;
            end
        end
        wr_req = 1'b0; rd_req = 1'b0;
        checks++; if (n != 10) begin failures++; $display("FAIL starve_events got %0d want 10", n); end
        checks++; if (seq !== 10'b1111011110) begin failures++; $display("FAIL starve_order got %b want 1111011110", seq); end
        checks++; if (maxRun != 4) begin failures++; $display("FAIL starve_max_run got %0d want 4", maxRun); end
        checks++; if (!rdOk) begin failures++; $display("FAIL starve_rd_data got %h want deadbeef", rd_data); end
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        int ackCyc [4];
        bit addrOk = 1'b1;
        logic [17:0] a;
        wr_addr = 18'h00100; wr_data = 32'hA0000000; wr_req = 1'b1;
        for (int c = 1; c <= 40 && acks < 4; c++) begin
            tick();
            a = 18'h00100 + 18'(acks);
            if (!xonWE && xopAddr !== a) addrOk = 1'b0;
            if (wr_ack) begin
                ackCyc[acks] = c;
                acks++;
                if (acks < 4) begin
                    wr_addr = 18'h00100 + 18'(acks);
                    wr_data = 32'hA0000000 | 32'(acks);
                end else begin
                    wr_req = 1'b0;
                end
            end
        end
        checks++; if (acks != 4) begin failures++; $display("FAIL b2b_acks got %0d want 4", acks); end
        checks++; if (ackCyc[0] != 4) begin failures++; $display("FAIL b2b_first_ack got %0d want 4", ackCyc[0]); end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (ackCyc[i] - ackCyc[i-1] != 5) begin
                failures++; $display("FAIL b2b_spacing_%0d got %0d want 5", i, ackCyc[i] - ackCyc[i-1]);
            end
        end
        checks++; if (!addrOk) begin failures++; $display("FAIL b2b_addr_seq got %h", xopAddr); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[18'h00100 + 18'(i)] !== (32'hA0000000 | 32'(i))) begin
                failures++; $display("FAIL b2b_mem_%0d got %h want %h", i, mem[18'h00100 + 18'(i)], 32'hA0000000 | 32'(i));
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_write();
        int stray = 0;
        wr_addr = 18'h00020; wr_data = 32'hAAAA5555; wr_req = 1'b1;
        tick();   // WR_SETUP
        tick();   // first WR_PULSE cycle
        checks++; if (xonWE !== 1'b0) begin failures++; $display("FAIL rst_pre_we got %b want 0", xonWE); end
        reset = 1'b1; wr_req = 1'b0;
        tick();
        checks++;
        if ({xonWE, xonCE1, xonCE2, sram_dq_oe, wr_ack} !== 5'b11100) begin
            failures++; $display("FAIL rst_abort got we,ce1,ce2,dqoe,ack=%b want 11100",
                                 {xonWE, xonCE1, xonCE2, sram_dq_oe, wr_ack});
        end
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (wr_ack) stray++;
        end
        checks++; if (stray != 0) begin failures++; $display("FAIL rst_no_ack got %0d acks want 0", stray); end
        poke(18'h00030, 32'hCAFEF00D);
        read_check("rst_rd", 18'h00030, 32'hCAFEF00D);
        tick();
    endtask

    initial begin
        test_reset();
        test_write_only();
        test_read_only();
        test_starvation();
        test_back_to_back();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
